cache_miss_controller: RTL and testbench
========================================

// Module: cache_miss_controller
// PURPOSE
//  Sequencing FSM for one 4-way set-associative, write-back, write-allocate data cache.
//  Sits between CPU port, tag/data array + FIFO replacement unit (lk_*/arr_*), and memory bus.
//  Hit: one LOOKUP cycle. Miss: optional dirty-victim writeback burst, refill burst, install, re-lookup.
// PARAMETERS
//  TAG_WIDTH     24  tag bits = 32 - SET_WIDTH - OFFSET_WIDTH
//  SET_WIDTH      4  set index bits
//  OFFSET_WIDTH   4  byte offset within line; WORDS = 2**(OFFSET_WIDTH-2) = 4 words/line
// PORTS
//  clk            in   1   clock, all state on rising edge
//  resetn         in   1   asynchronous, active-low reset
//  cpu_req        in   1   request; sampled only in IDLE
//  cpu_we         in   1   1 = word store, 0 = word load
//  cpu_addr       in   32  word-aligned byte address
//  cpu_wdata      in   32  store data
//  cpu_ready      out  1   one-cycle pulse: access complete
//  cpu_rdata      out  32  load data, valid while cpu_ready=1
//  lk_hit         in   1   lookup result for arr_set/tag of latched address
//  lk_dirty       in   1   dirty bit of hit way, else of FIFO victim way
//  lk_victim_tag  in   TAG_WIDTH  tag of FIFO victim way (valid on miss)
//  lk_rdata       in   32  word arr_offset of hit way, else of victim way
//  arr_tag        out  TAG_WIDTH  tag field of latched address
//  arr_set        out  SET_WIDTH  set index of latched address
//  arr_offset     out  OFFSET_WIDTH-2  word index into line
//  arr_we         out  1   write arr_wdata into hit/victim way at arr_offset
//  arr_wdata      out  32  array write data
//  arr_mark_dirty out  1   set dirty bit of hit way (with arr_we)
//  arr_fill       out  1   install: victim tag<=arr_tag, valid<=1, dirty<=0
//  repl_en        out  1   advance FIFO pointer of arr_set (one pulse per fill)
//  mem_req        out  1   memory request, held until mem_ack
//  mem_we         out  1   1 = write word, 0 = read word
//  mem_addr       out  32  word address, stable while mem_req
//  mem_wdata      out  32  write data, stable while mem_req
//  mem_rdata      in   32  read data, valid with mem_ack
//  mem_ack        in   1   transfer done this cycle; may coincide with first mem_req cycle
// BEHAVIOUR
//  Reset (async, resetn=0): state IDLE, cnt=0, latches cleared; every output 0. Mid-burst reset
//   drops mem_req immediately, no fill/repl_en; line stays as before (partial refill data, old tag).
//  IDLE: cpu_req=1 -> latch addr/we/wdata -> LOOKUP. Request not re-sampled until back in IDLE.
//  LOOKUP (arr_* driven from latch, arr_offset = addr word field):
//   hit & load  -> cpu_rdata=lk_rdata, cpu_ready=1 -> IDLE (ready one cycle after acceptance).
//   hit & store -> arr_we=1, arr_wdata=latched data, arr_mark_dirty=1, cpu_ready=1 -> IDLE.
//   miss & lk_dirty  -> latch lk_victim_tag, cnt=0 -> WRITEBACK.
//   miss & !lk_dirty -> cnt=0 -> REFILL.
//  WRITEBACK: arr_offset=cnt; mem_req=1, mem_we=1, mem_addr={victim_tag,set,cnt,2'b00},
//   mem_wdata=lk_rdata. On mem_ack: cnt++; ack at cnt=WORDS-1 -> cnt=0, REFILL.
//  REFILL: mem_req=1, mem_we=0, mem_addr={tag,set,cnt,2'b00}, arr_offset=cnt. On mem_ack:
//   arr_we=1, arr_wdata=mem_rdata (victim way), cnt++. Ack at cnt=WORDS-1 additionally
//   arr_fill=1, repl_en=1 same cycle -> LOOKUP (re-lookup hits; store then completes there).
//  cnt is OFFSET_WIDTH-2 bits, wraps to 0 naturally after last word; no mem_req gap between words.
//  mem_req=0 outside WRITEBACK/REFILL; arr_we/arr_fill/repl_en/cpu_ready are never asserted
//   while mem_ack absent in burst states. cpu_rdata=0 when cpu_ready=0.
//  Assertion: LOOKUP entered from REFILL must see lk_hit=1.
// STRUCTURE
//  cache_pkg: ctrl_state_t enum {IDLE,LOOKUP,WRITEBACK,REFILL}, WORDS localparam,
//   functions addr_tag/addr_set/addr_word and mk_addr(tag,set,word).
//  Sub-module cache_burst_seq: word counter + mem_req/mem_ack handshake, start/last/beat outputs.
//  Top: FSM, address/data latches, output decode.
// TESTING
//  1 Load hit: array preloaded, req addr 0x0000_1234 -> cpu_ready next cycle, rdata = stored word, mem_req never 1.
//  2 Store hit: req we=1 data 0xDEAD_BEEF -> arr_we+arr_mark_dirty in LOOKUP, cpu_ready same cycle.
//  3 Clean miss, mem_ack 2 cycles late: 4 reads at +0,+4,+8,+C, arr_fill+repl_en once, ready 1 cycle after fill.
//  4 Dirty miss: 4 writes to {victim_tag,set} with victim data, then 4 reads, then ready; no mem_req gap.
//  5 Store miss: write-allocate refill, then arr_we with store data and dirty set in re-LOOKUP.
//  6 resetn low during REFILL word 2 -> all outputs 0 immediately; no arr_fill; next req served normally.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and address helpers for the data-cache miss controller.
// Address layout: {tag, set, word, 2'b00}.
package cache_pkg;

   localparam int CACHE_TAG_W  = 24;
   localparam int CACHE_SET_W  = 4;
   localparam int CACHE_OFF_W  = 4;
   localparam int CACHE_WORD_W = CACHE_OFF_W - 2;
   localparam int WORDS        = 2 ** CACHE_WORD_W;

   typedef enum logic [1:0] {
      IDLE,
      LOOKUP,
      WRITEBACK,
      REFILL
   } ctrl_state_t;

   function automatic logic [CACHE_TAG_W-1:0] addr_tag(input logic [31:0] a);
      return a[31 -: CACHE_TAG_W];
   endfunction

   function automatic logic [CACHE_SET_W-1:0] addr_set(input logic [31:0] a);
      return a[CACHE_OFF_W +: CACHE_SET_W];
   endfunction

   function automatic logic [CACHE_WORD_W-1:0] addr_word(input logic [31:0] a);
      return a[2 +: CACHE_WORD_W];
   endfunction

   function automatic logic [31:0] mk_addr(input logic [CACHE_TAG_W-1:0]  tag,
                                           input logic [CACHE_SET_W-1:0]  set,
                                           input logic [CACHE_WORD_W-1:0] word);
      return {tag, set, word, 2'b00};
   endfunction

endpackage

// File: rtl/cache_burst_seq.sv
// Word counter and memory handshake for one line-sized burst.
// mem_req follows the burst state directly, so consecutive words have no request gap.
module cache_burst_seq
   import cache_pkg::*;
#(
   parameter int CNT_W = CACHE_WORD_W
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             active,
   input  logic             mem_ack,
   output logic [CNT_W-1:0] cnt,
   output logic             mem_req,
   output logic             beat,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else if (start) begin
         cnt_q <= '0;
      end else if (beat) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign cnt     = cnt_q;
   assign mem_req = active;
   assign beat    = active && mem_ack;
   assign last    = beat && (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/cache_miss_controller.sv
// Sequencing FSM for a 4-way write-back, write-allocate data cache:
// lookup, optional dirty-victim writeback, refill, install, re-lookup.
module cache_miss_controller
   import cache_pkg::*;
#(
   parameter int TAG_WIDTH    = CACHE_TAG_W,
   parameter int SET_WIDTH    = CACHE_SET_W,
   parameter int OFFSET_WIDTH = CACHE_OFF_W
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    cpu_req,
   input  logic                    cpu_we,
   input  logic [31:0]             cpu_addr,
   input  logic [31:0]             cpu_wdata,
   output logic                    cpu_ready,
   output logic [31:0]             cpu_rdata,
   input  logic                    lk_hit,
   input  logic                    lk_dirty,
   input  logic [TAG_WIDTH-1:0]    lk_victim_tag,
   input  logic [31:0]             lk_rdata,
   output logic [TAG_WIDTH-1:0]    arr_tag,
   output logic [SET_WIDTH-1:0]    arr_set,
   output logic [OFFSET_WIDTH-3:0] arr_offset,
   output logic                    arr_we,
   output logic [31:0]             arr_wdata,
   output logic                    arr_mark_dirty,
   output logic                    arr_fill,
   output logic                    repl_en,
   output logic                    mem_req,
   output logic                    mem_we,
   output logic [31:0]             mem_addr,
   output logic [31:0]             mem_wdata,
   input  logic [31:0]             mem_rdata,
   input  logic                    mem_ack
);

   ctrl_state_t state, state_nx;

   logic [31:0]             addr_q;
   logic [31:0]             wdata_q;
   logic                    we_q;
   logic [TAG_WIDTH-1:0]    vtag_q;
   logic                    refilled_q;

   logic [OFFSET_WIDTH-3:0] cnt;
   logic                    bursting;
   logic                    beat;
   logic                    last;

   assign bursting = (state == WRITEBACK) || (state == REFILL);

   cache_burst_seq #(.CNT_W(OFFSET_WIDTH-2)) u_burst (
      .clk     (clk),
      .resetn  (resetn),
      .start   (state == LOOKUP),
      .active  (bursting),
      .mem_ack (mem_ack),
      .cnt     (cnt),
      .mem_req (mem_req),
      .beat    (beat),
      .last    (last)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Request latches; the victim tag is captured on the lookup that chose to write back
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         vtag_q     <= '0;
         refilled_q <= 1'b0;
      end else begin
         if (state == IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            we_q    <= cpu_we;
         end
         if (state == LOOKUP && !lk_hit && lk_dirty) begin
            vtag_q <= lk_victim_tag;
         end
         if (state == REFILL && last) begin
            refilled_q <= 1'b1;
         end else if (state == LOOKUP) begin
            refilled_q <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nx       = state;
      cpu_ready      = 1'b0;
      cpu_rdata      = '0;
      arr_tag        = addr_tag(addr_q);
      arr_set        = addr_set(addr_q);
      arr_offset     = '0;
      arr_we         = 1'b0;
      arr_wdata      = '0;
      arr_mark_dirty = 1'b0;
      arr_fill       = 1'b0;
      repl_en        = 1'b0;
      mem_we         = 1'b0;
      mem_addr       = '0;
      mem_wdata      = '0;
      case (state)
         IDLE: begin
            if (cpu_req) state_nx = LOOKUP;
         end
         LOOKUP: begin
            arr_offset = addr_word(addr_q);
            if (lk_hit) begin
               cpu_ready = 1'b1;
               if (we_q) begin
                  arr_we         = 1'b1;
                  arr_wdata      = wdata_q;
                  arr_mark_dirty = 1'b1;
               end else begin
                  cpu_rdata = lk_rdata;
               end
               state_nx = IDLE;
            end else if (lk_dirty) begin
               state_nx = WRITEBACK;
            end else begin
               state_nx = REFILL;
            end
         end
         WRITEBACK: begin
            arr_offset = cnt;
            mem_we     = 1'b1;
            mem_addr   = mk_addr(vtag_q, addr_set(addr_q), cnt);
            mem_wdata  = lk_rdata;
            if (last) state_nx = REFILL;
         end
         REFILL: begin
            arr_offset = cnt;
            mem_addr   = mk_addr(addr_tag(addr_q), addr_set(addr_q), cnt);
            if (beat) begin
               arr_we    = 1'b1;
               arr_wdata = mem_rdata;
            end
            if (last) begin
               arr_fill = 1'b1;
               repl_en  = 1'b1;
               state_nx = LOOKUP;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // A freshly installed line must hit on the re-lookup
   a_refill_hits: assert property (@(posedge clk) disable iff (!resetn)
      (state == LOOKUP && refilled_q) |-> lk_hit);

endmodule

// File: tb/tb_cache_miss_controller.sv
// Directed bench for cache_miss_controller: hits, clean/dirty/store misses, mid-burst reset.
module tb_cache_miss_controller;

   logic        clk;
   logic        resetn;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic        cpu_ready;
   logic [31:0] cpu_rdata;
   logic        lk_hit, lk_dirty;
   logic [23:0] lk_victim_tag;
   logic [31:0] lk_rdata;
   logic [23:0] arr_tag;
   logic [3:0]  arr_set;
   logic [1:0]  arr_offset;
   logic        arr_we;
   logic [31:0] arr_wdata;
   logic        arr_mark_dirty, arr_fill, repl_en;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ack;

   int checks   = 0;
   int failures = 0;

   cache_miss_controller dut (
      .clk            (clk),
      .resetn         (resetn),
      .cpu_req        (cpu_req),
      .cpu_we         (cpu_we),
      .cpu_addr       (cpu_addr),
      .cpu_wdata      (cpu_wdata),
      .cpu_ready      (cpu_ready),
      .cpu_rdata      (cpu_rdata),
      .lk_hit         (lk_hit),
      .lk_dirty       (lk_dirty),
      .lk_victim_tag  (lk_victim_tag),
      .lk_rdata       (lk_rdata),
      .arr_tag        (arr_tag),
      .arr_set        (arr_set),
      .arr_offset     (arr_offset),
      .arr_we         (arr_we),
      .arr_wdata      (arr_wdata),
      .arr_mark_dirty (arr_mark_dirty),
      .arr_fill       (arr_fill),
      .repl_en        (repl_en),
      .mem_req        (mem_req),
      .mem_we         (mem_we),
      .mem_addr       (mem_addr),
      .mem_wdata      (mem_wdata),
      .mem_rdata      (mem_rdata),
      .mem_ack        (mem_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk);
      #2;
   endtask

   task automatic settle;
      #1;
   endtask

   // Refill words [0, nwords) of line base, each acked after `delay` idle cycles
   task automatic do_refill(input string tag, input logic [31:0] base, input int delay,
                            input int nwords);
      for (int w = 0; w < nwords; w++) begin
         for (int d = 0; d < delay; d++) begin
            mem_ack = 1'b0;
            settle;
            chk({tag, "_wait_req"}, 32'(mem_req), 32'd1);
            chk({tag, "_wait_addr"}, mem_addr, base + 32'(4 * w));
            chk({tag, "_wait_arr_we"}, 32'(arr_we), 32'd0);
            chk({tag, "_wait_fill"}, 32'(arr_fill), 32'd0);
            cyc;
         end
         mem_ack   = 1'b1;
         mem_rdata = 32'hF000_0000 + base + 32'(w);
         settle;
         chk({tag, "_req"}, 32'(mem_req), 32'd1);
         chk({tag, "_we"}, 32'(mem_we), 32'd0);
         chk({tag, "_addr"}, mem_addr, base + 32'(4 * w));
         chk({tag, "_off"}, 32'(arr_offset), 32'(w));
         chk({tag, "_arr_we"}, 32'(arr_we), 32'd1);
         chk({tag, "_arr_wdata"}, arr_wdata, 32'hF000_0000 + base + 32'(w));
         chk({tag, "_fill"}, 32'(arr_fill), (w == 3) ? 32'd1 : 32'd0);
         chk({tag, "_repl"}, 32'(repl_en), (w == 3) ? 32'd1 : 32'd0);
         chk({tag, "_ready"}, 32'(cpu_ready), 32'd0);
         cyc;
         mem_ack = 1'b0;
      end
   endtask

   initial begin
      resetn = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      lk_hit = 1'b0; lk_dirty = 1'b0; lk_victim_tag = '0; lk_rdata = '0;
      mem_rdata = '0; mem_ack = 1'b0;
      #3;
      chk("rst_ready", 32'(cpu_ready), 32'd0);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_arr_tag", 32'(arr_tag), 32'd0);
      chk("rst_arr_we", 32'(arr_we), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      cyc;

      // 1: load hit at 0x1234 -> tag 0x12, set 3, word 1
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1234;
      settle;
      chk("t1_idle_ready", 32'(cpu_ready), 32'd0);
      cyc;
      cpu_req = 1'b0; lk_hit = 1'b1; lk_rdata = 32'hCAFE_0001;
      settle;
      chk("t1_tag", 32'(arr_tag), 32'h12);
      chk("t1_set", 32'(arr_set), 32'd3);
      chk("t1_off", 32'(arr_offset), 32'd1);
      chk("t1_ready", 32'(cpu_ready), 32'd1);
      chk("t1_rdata", cpu_rdata, 32'hCAFE_0001);
      chk("t1_mem_req", 32'(mem_req), 32'd0);
      chk("t1_arr_we", 32'(arr_we), 32'd0);
      cyc;
      settle;
      chk("t1_after_ready", 32'(cpu_ready), 32'd0);
      chk("t1_after_rdata", cpu_rdata, 32'd0);

      // 2: store hit at 0x1238 -> word 2
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_1238; cpu_wdata = 32'hDEAD_BEEF;
      cyc;
      cpu_req = 1'b0; cpu_wdata = 32'h0; lk_hit = 1'b1;
      settle;
      chk("t2_arr_we", 32'(arr_we), 32'd1);
      chk("t2_wdata", arr_wdata, 32'hDEAD_BEEF);
      chk("t2_dirty", 32'(arr_mark_dirty), 32'd1);
      chk("t2_off", 32'(arr_offset), 32'd2);
      chk("t2_ready", 32'(cpu_ready), 32'd1);
      chk("t2_rdata", cpu_rdata, 32'd0);
      chk("t2_mem_req", 32'(mem_req), 32'd0);
      cyc;

      // 3: clean load miss at 0x5670, each word acked two cycles late
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_5670;
      cyc;
      cpu_req = 1'b0; lk_hit = 1'b0; lk_dirty = 1'b0;
      settle;
      chk("t3_miss_ready", 32'(cpu_ready), 32'd0);
      chk("t3_miss_mem_req", 32'(mem_req), 32'd0);
      cyc;
      do_refill("t3", 32'h0000_5670, 2, 4);
      lk_hit = 1'b1; lk_rdata = 32'h1111_0000;
      settle;
      chk("t3_relook_ready", 32'(cpu_ready), 32'd1);
      chk("t3_relook_rdata", cpu_rdata, 32'h1111_0000);
      chk("t3_relook_fill", 32'(arr_fill), 32'd0);
      chk("t3_relook_mem_req", 32'(mem_req), 32'd0);
      cyc;
      settle;
      chk("t3_idle_ready", 32'(cpu_ready), 32'd0);

      // 4: dirty load miss at 0x9AB0, victim tag 0xABCDEF, acks with first request cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_9AB0;
      cyc;
      cpu_req = 1'b0; lk_hit = 1'b0; lk_dirty = 1'b1; lk_victim_tag = 24'hABCDEF;
      settle;
      chk("t4_miss_mem_req", 32'(mem_req), 32'd0);
      cyc;
      lk_victim_tag = 24'h0; lk_dirty = 1'b0;
      for (int w = 0; w < 4; w++) begin
         lk_rdata = 32'hD000_0000 + 32'(w);
         mem_ack  = 1'b1;
         settle;
         chk("t4_wb_req", 32'(mem_req), 32'd1);
         chk("t4_wb_we", 32'(mem_we), 32'd1);
         chk("t4_wb_addr", mem_addr, 32'hABCD_EFB0 + 32'(4 * w));
         chk("t4_wb_wdata", mem_wdata, 32'hD000_0000 + 32'(w));
         chk("t4_wb_off", 32'(arr_offset), 32'(w));
         chk("t4_wb_arr_we", 32'(arr_we), 32'd0);
         chk("t4_wb_fill", 32'(arr_fill), 32'd0);
         cyc;
      end
      mem_ack = 1'b0;
      do_refill("t4", 32'h0000_9AB0, 0, 4);
      lk_hit = 1'b1; lk_rdata = 32'h4444_0000;
      settle;
      chk("t4_relook_ready", 32'(cpu_ready), 32'd1);
      chk("t4_relook_rdata", cpu_rdata, 32'h4444_0000);
      cyc;

      // 5: store miss at 0x3C44 -> refill, then store completes on re-lookup
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_3C44; cpu_wdata = 32'h1234_5678;
      cyc;
      cpu_req = 1'b0; cpu_wdata = 32'h0; lk_hit = 1'b0; lk_dirty = 1'b0;
      settle;
      chk("t5_miss_arr_we", 32'(arr_we), 32'd0);
      chk("t5_miss_ready", 32'(cpu_ready), 32'd0);
      cyc;
      do_refill("t5", 32'h0000_3C40, 0, 4);
      lk_hit = 1'b1;
      settle;
      chk("t5_st_arr_we", 32'(arr_we), 32'd1);
      chk("t5_st_wdata", arr_wdata, 32'h1234_5678);
      chk("t5_st_dirty", 32'(arr_mark_dirty), 32'd1);
      chk("t5_st_off", 32'(arr_offset), 32'd1);
      chk("t5_st_ready", 32'(cpu_ready), 32'd1);
      cyc;

      // 6: reset while waiting on refill word 2 of 0x7700
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_7700;
      cyc;
      cpu_req = 1'b0; lk_hit = 1'b0; lk_dirty = 1'b0;
      cyc;
      do_refill("t6", 32'h0000_7700, 0, 2);
      settle;
      chk("t6_w2_req", 32'(mem_req), 32'd1);
      chk("t6_w2_addr", mem_addr, 32'h0000_7708);
      chk("t6_w2_off", 32'(arr_offset), 32'd2);
      #1;
      resetn = 1'b0; mem_ack = 1'b1;
      settle;
      chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
      chk("t6_rst_mem_addr", mem_addr, 32'd0);
      chk("t6_rst_arr_we", 32'(arr_we), 32'd0);
      chk("t6_rst_fill", 32'(arr_fill), 32'd0);
      chk("t6_rst_repl", 32'(repl_en), 32'd0);
      chk("t6_rst_ready", 32'(cpu_ready), 32'd0);
      chk("t6_rst_tag", 32'(arr_tag), 32'd0);
      cyc;
      mem_ack = 1'b0;
      cyc;
      chk("t6_hold_fill", 32'(arr_fill), 32'd0);
      resetn = 1'b1;
      cyc;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1234;
      cyc;
      cpu_req = 1'b0; lk_hit = 1'b1; lk_rdata = 32'h6666_0001;
      settle;
      chk("t6_post_ready", 32'(cpu_ready), 32'd1);
      chk("t6_post_rdata", cpu_rdata, 32'h6666_0001);
      cyc;
      cpu_req = 1'b1; cpu_addr = 32'h0000_7700;
      cyc;
      cpu_req = 1'b0; lk_hit = 1'b0;
      cyc;
      do_refill("t6_re", 32'h0000_7700, 0, 4);
      lk_hit = 1'b1; lk_rdata = 32'h7777_0000;
      settle;
      chk("t6_re_ready", 32'(cpu_ready), 32'd1);
      cyc;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
